pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the 5-stage RISC-V pipeline.
Each cycle it selects the next PC from PC+4, a jump target from ID, a taken-branch target from EX, or a trap vector.
It freezes the PC on memory busywait, inserts load-use bubbles, and buffers redirects that arrive while the pipeline is frozen.
It generates the stall and flush controls for the IF/ID and ID/EX pipeline registers.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
XLEN, 32, address width

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  asynchronous, active-low reset
imem_busywait  in  1  instruction memory not ready
dmem_busywait  in  1  data memory not ready
load_use_hazard  in  1  from hazard unit; ID instruction needs a load result still in EX
jump_valid  in  1  JAL/JALR resolved in ID
jump_target  in  XLEN  jump destination
branch_taken  in  1  taken branch resolved in EX
branch_target  in  XLEN  branch destination
trap_req  in  1  exception or interrupt accepted
trap_vector  in  XLEN  handler address (mtvec)
PC  out  XLEN  current fetch address (registered)
PC_plus4  out  XLEN  PC+4, combinational
fetch_valid  out  1  instruction at PC is to be issued
stall_if  out  1  hold IF/ID register
stall_id  out  1  hold ID/EX register
flush_ifid  out  1  squash IF/ID contents
flush_idex  out  1  squash ID/EX contents (insert bubble)
misaligned_target  out  1  registered; redirect target had bits[1:0] != 0

Behaviour:
- RESET=0, any time and regardless of CLK: PC=RESET_VECTOR, state=BOOT, pending_valid=0, misaligned_target=0. Outputs fetch_valid, stall_*, and flush_* are all 0.
- States: BOOT, RUN, PENDING.
- freeze = imem_busywait | dmem_busywait.
- redir = trap_req | branch_taken | jump_valid.
- Redirect priority: trap_req > branch_taken > jump_valid.
- Redirect target: low 2 bits forced to 0. misaligned_target is set on the edge that loads the target if the original bits[1:0] != 0, and is cleared on the next edge.
- BOOT: lasts exactly 1 cycle after RESET deasserts. fetch_valid=0, PC held; next state RUN. The first fetch is at RESET_VECTOR.
- RUN, redir and !freeze:
  - PC <= target on the next edge.
  - flush_ifid=1.
  - flush_idex=1 for trap or branch; flush_idex=0 for jump.
  - Redirect overrides load_use_hazard; stall_* = 0.
- RUN, redir and freeze:
  - Capture target and kind into the pending register; PC held.
  - stall_if=stall_id=1; no flush asserted.
  - Next state PENDING.
- RUN, no redir, freeze: PC held, stall_if=stall_id=1, flush_*=0.
- RUN, no redir, !freeze, load_use_hazard: PC held, stall_if=stall_id=1, flush_idex=1 (one bubble per hazard cycle).
- RUN, otherwise: PC <= PC+4. PC+4 from 32'hFFFF_FFFC wraps to 0 with no flag.
- PENDING, freeze still high:
  - PC held, stall_if=stall_id=1.
  - A new redirect of strictly higher priority overwrites the pending entry; equal or lower priority is ignored.
- PENDING, freeze low:
  - PC <= pending target; flushes are asserted per the pending kind, as in RUN.
  - Clear pending; next state RUN.
  - A simultaneous new redirect of higher priority wins and is applied instead.
- fetch_valid = (state != BOOT) & !imem_busywait & !flush_ifid.
- Reset mid-stall or while PENDING discards the pending redirect; the sequence restarts at BOOT.

Decomposition:
- Shared package pc_seq_pkg:
  - state enum {BOOT, RUN, PENDING}
  - redirect-kind enum {RK_NONE, RK_JUMP, RK_BRANCH, RK_TRAP}, encoded so a higher numeric value means higher priority
  - XLEN and RESET_VECTOR defaults
- One natural sub-module, pc_redirect_select: a combinational priority mux producing kind, aligned target, and misaligned bit. It is instanced once for the live request path.

Test Plan:
- Reset release, no stalls -> PC=0 in BOOT and the first RUN cycle. PC then steps 4, 8, 12. fetch_valid=0 only during BOOT.
- branch_taken=1, branch_target=32'h100, at PC=32'h20 with no freeze -> flush_ifid=flush_idex=1 that cycle; next PC=32'h100.
- imem_busywait high for 3 cycles at PC=32'h40 -> PC stays 32'h40 and stall_if=1 for 3 cycles; PC=32'h44 one cycle after release.
- dmem_busywait high while jump_valid, jump_target=32'h200 -> state PENDING, PC held. trap_req with trap_vector=32'h80 then arrives during the stall. On release, PC=32'h80 with flush_ifid=flush_idex=1.
- load_use_hazard for 1 cycle at PC=32'h10 -> PC held one cycle, flush_idex=1, stall_if=1; then PC=32'h14.
- jump_target=32'h102 -> PC=32'h100, misaligned_target=1 for one cycle. Separately, RESET=0 asserted while PENDING -> pending cleared and PC=RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_seq_pkg                                                      |
// | Purpose  : Shared types and defaults for the PC fetch sequencer.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pc_seq_pkg;

  localparam int unsigned c_xlen         = 32;
  localparam logic [31:0] c_reset_vector = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } pc_state_e;

  // Numeric order is the redirect priority: larger value wins.
  typedef enum logic [1:0] {
    RK_NONE   = 2'd0,
    RK_JUMP   = 2'd1,
    RK_BRANCH = 2'd2,
    RK_TRAP   = 2'd3
  } redir_kind_e;

  // Jumps resolve in ID, so only the IF/ID slot holds a wrong-path instruction.
  function automatic logic kind_flushes_idex(input redir_kind_e kind);
    return (kind == RK_BRANCH) || (kind == RK_TRAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_redirect_select                                              |
// | Purpose  : Priority mux of live redirect requests (trap > branch > jump).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pc_redirect_select
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN = c_xlen
) (
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  output redir_kind_e     kind,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] w_raw;

  always_comb begin
    kind  = RK_NONE;
    w_raw = jump_target;
    if (trap_req) begin
      kind  = RK_TRAP;
      w_raw = trap_vector;
    end else if (branch_taken) begin
      kind  = RK_BRANCH;
      w_raw = branch_target;
    end else if (jump_valid) begin
      kind  = RK_JUMP;
      w_raw = jump_target;
    end
  end

  assign target     = {w_raw[XLEN-1:2], 2'b00};
  assign misaligned = (kind != RK_NONE) && (w_raw[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_sequencer                                              |
// | Purpose  : PC owner and IF/ID, ID/EX stall/flush sequencing.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN         = c_xlen,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(c_reset_vector)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            imem_busywait,
  input  logic            dmem_busywait,
  input  logic            load_use_hazard,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus4,
  output logic            fetch_valid,
  output logic            stall_if,
  output logic            stall_id,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misaligned_target
);

  pc_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc;
  redir_kind_e     r_pend_kind;
  logic [XLEN-1:0] r_pend_target;
  logic            r_pend_mis;
  logic            r_misaligned;

  redir_kind_e     w_live_kind;
  logic [XLEN-1:0] w_live_target;
  logic            w_live_mis;
  redir_kind_e     w_sel_kind;
  logic [XLEN-1:0] w_sel_target;
  logic            w_sel_mis;
  logic            w_freeze, w_redir;
  logic            w_load, w_pc_inc, w_capture;

  pc_redirect_select #(.XLEN(XLEN)) u_live_sel (
    .trap_req      (trap_req),
    .trap_vector   (trap_vector),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .kind          (w_live_kind),
    .target        (w_live_target),
    .misaligned    (w_live_mis)
  );

  assign w_freeze = imem_busywait | dmem_busywait;
  assign w_redir  = trap_req | branch_taken | jump_valid;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     if (w_redir && w_freeze) w_state_nxt = PENDING;
      PENDING: if (!w_freeze) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    w_load       = 1'b0;
    w_pc_inc     = 1'b0;
    w_capture    = 1'b0;
    w_sel_kind   = w_live_kind;
    w_sel_target = w_live_target;
    w_sel_mis    = w_live_mis;
    unique case (r_state)
      RUN: begin
        if (w_redir && !w_freeze) begin
          w_load     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = kind_flushes_idex(w_live_kind);
        end else if (w_redir || w_freeze) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          w_capture = w_redir;
        end else if (load_use_hazard) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          flush_idex = 1'b1;
        end else begin
          w_pc_inc = 1'b1;
        end
      end
      PENDING: begin
        // Only a strictly higher-priority live request displaces the buffered one.
        if (w_live_kind <= r_pend_kind) begin
          w_sel_kind   = r_pend_kind;
          w_sel_target = r_pend_target;
          w_sel_mis    = r_pend_mis;
        end
        if (w_freeze) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          w_capture = (w_live_kind > r_pend_kind);
        end else begin
          w_load     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = kind_flushes_idex(w_sel_kind);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc          <= RESET_VECTOR;
      r_misaligned  <= 1'b0;
      r_pend_kind   <= RK_NONE;
      r_pend_target <= '0;
      r_pend_mis    <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      if (w_load) begin
        r_pc         <= w_sel_target;
        r_misaligned <= w_sel_mis;
      end else if (w_pc_inc) begin
        r_pc <= PC_plus4;
      end
      if (w_capture) begin
        r_pend_kind   <= w_live_kind;
        r_pend_target <= w_live_target;
        r_pend_mis    <= w_live_mis;
      end else if (w_load) begin
        r_pend_kind <= RK_NONE;
      end
    end
  end

  assign PC                = r_pc;
  assign PC_plus4          = r_pc + XLEN'(4);
  assign misaligned_target = r_misaligned;
  assign fetch_valid       = (r_state != BOOT) && !imem_busywait && !flush_ifid;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_fetch_sequencer                                           |
// | Purpose  : Directed plus random self-checking bench for the PC sequencer.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_sequencer;

  localparam logic [31:0] c_rv = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        imem_busywait, dmem_busywait, load_use_hazard;
  logic        jump_valid, branch_taken, trap_req;
  logic [31:0] jump_target, branch_target, trap_vector;
  logic [31:0] PC, PC_plus4;
  logic        fetch_valid, stall_if, stall_id, flush_ifid, flush_idex, misaligned_target;

  int checks = 0;
  int errors = 0;

  // Reference model: boot flag, pending flag, PC, buffered redirect (priority rank + raw target).
  bit          m_boot, m_pend, m_mis;
  logic [31:0] m_pc, m_pt;
  int          m_pk;

  pc_fetch_sequencer #(.XLEN(32), .RESET_VECTOR(c_rv)) dut (
    .CLK (CLK), .RESET (RESET),
    .imem_busywait (imem_busywait), .dmem_busywait (dmem_busywait),
    .load_use_hazard (load_use_hazard),
    .jump_valid (jump_valid), .jump_target (jump_target),
    .branch_taken (branch_taken), .branch_target (branch_target),
    .trap_req (trap_req), .trap_vector (trap_vector),
    .PC (PC), .PC_plus4 (PC_plus4), .fetch_valid (fetch_valid),
    .stall_if (stall_if), .stall_id (stall_id),
    .flush_ifid (flush_ifid), .flush_idex (flush_idex),
    .misaligned_target (misaligned_target)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    imem_busywait = 0; dmem_busywait = 0; load_use_hazard = 0;
    jump_valid = 0; branch_taken = 0; trap_req = 0;
    jump_target = 0; branch_target = 0; trap_vector = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    int          lk, k;
    logic [31:0] lt, t;
    bit          frz, e_si, e_fi, e_fe, e_fv, n_boot, n_pend, n_mis;
    logic [31:0] n_pc, n_pt;
    int          n_pk;
    #1;
    frz = imem_busywait | dmem_busywait;
    lk = 0; lt = 0;
    if (trap_req)          begin lk = 3; lt = trap_vector;   end
    else if (branch_taken) begin lk = 2; lt = branch_target; end
    else if (jump_valid)   begin lk = 1; lt = jump_target;   end
    e_si = 0; e_fi = 0; e_fe = 0;
    n_boot = 0; n_pend = m_pend; n_pc = m_pc; n_pk = m_pk; n_pt = m_pt; n_mis = 0;
    k = 0; t = 0;
    if (m_boot) begin
      k = 0;
    end else if (!m_pend) begin
      if (lk != 0 && !frz) begin
        k = lk; t = lt;
      end else if (lk != 0) begin
        e_si = 1; n_pend = 1; n_pk = lk; n_pt = lt;
      end else if (frz) begin
        e_si = 1;
      end else if (load_use_hazard) begin
        e_si = 1; e_fe = 1;
      end else begin
        n_pc = m_pc + 32'd4;
      end
    end else begin
      if (frz) begin
        e_si = 1;
        if (lk > m_pk) begin n_pk = lk; n_pt = lt; end
      end else begin
        if (lk > m_pk) begin k = lk; t = lt; end
        else           begin k = m_pk; t = m_pt; end
        n_pend = 0;
      end
    end
    if (k != 0) begin
      e_fi  = 1;
      e_fe  = (k >= 2);
      n_pc  = t & 32'hFFFF_FFFC;
      n_mis = (t[1:0] != 2'b00);
    end
    e_fv = !m_boot && !imem_busywait && !e_fi;
    chk("pc", PC, m_pc);
    chk("pc_plus4", PC_plus4, m_pc + 32'd4);
    chk1("misaligned", misaligned_target, m_mis);
    chk1("fetch_valid", fetch_valid, e_fv);
    chk1("stall_if", stall_if, e_si);
    chk1("stall_id", stall_id, e_si);
    chk1("flush_ifid", flush_ifid, e_fi);
    chk1("flush_idex", flush_idex, e_fe);
    @(posedge CLK); #1;
    m_boot = n_boot; m_pend = n_pend; m_pc = n_pc; m_pk = n_pk; m_pt = n_pt; m_mis = n_mis;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 0; #1;
    chk("rst_pc", PC, c_rv);
    chk1("rst_mis", misaligned_target, 1'b0);
    chk1("rst_fetch_valid", fetch_valid, 1'b0);
    chk1("rst_stall_if", stall_if, 1'b0);
    chk1("rst_flush_ifid", flush_ifid, 1'b0);
    chk1("rst_flush_idex", flush_idex, 1'b0);
    m_boot = 1; m_pend = 0; m_pc = c_rv; m_pk = 0; m_pt = 0; m_mis = 0;
    @(negedge CLK);
    RESET = 1;
  endtask

  task automatic jump_to(input logic [31:0] a);
    idle(); jump_valid = 1; jump_target = a; tick(); idle();
  endtask

  initial begin
    idle();
    @(negedge CLK);
    do_reset();

    // Boot then sequential fetch
    tick(); tick(); tick(); tick();
    chk("seq_pc_12", PC, 32'h0000_000C);

    // Taken branch at 0x20
    jump_to(32'h20);
    branch_taken = 1; branch_target = 32'h100; tick(); idle();
    chk("branch_pc", PC, 32'h100);

    // Instruction memory busy for three cycles at 0x40
    jump_to(32'h40);
    imem_busywait = 1; tick(); tick(); tick();
    chk("imem_hold_pc", PC, 32'h40);
    idle(); tick();
    chk("imem_release_pc", PC, 32'h44);

    // Jump buffered under dmem stall, then overridden by a trap
    dmem_busywait = 1; jump_valid = 1; jump_target = 32'h200; tick();
    idle(); dmem_busywait = 1; trap_req = 1; trap_vector = 32'h80; tick();
    idle(); dmem_busywait = 1; tick();
    idle(); tick();
    chk("pending_trap_pc", PC, 32'h80);

    // Load-use bubble at 0x10
    jump_to(32'h10);
    load_use_hazard = 1; tick(); idle(); tick();
    chk("load_use_pc", PC, 32'h14);

    // Misaligned jump target
    jump_to(32'h102);
    chk("misaligned_pc", PC, 32'h100);
    chk1("misaligned_flag", misaligned_target, 1'b1);
    tick();
    chk1("misaligned_clear", misaligned_target, 1'b0);

    // PC wrap at the top of the address space
    jump_to(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", PC, 32'h0);

    // Reset while a redirect is pending
    dmem_busywait = 1; jump_valid = 1; jump_target = 32'h300; tick();
    idle();
    do_reset();
    tick(); tick();
    chk("post_reset_pc", PC, 32'h4);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      idle();
      imem_busywait   = ($urandom_range(0, 3) == 0);
      dmem_busywait   = ($urandom_range(0, 4) == 0);
      load_use_hazard = ($urandom_range(0, 3) == 0);
      jump_valid      = ($urandom_range(0, 4) == 0);
      branch_taken    = ($urandom_range(0, 5) == 0);
      trap_req        = ($urandom_range(0, 9) == 0);
      jump_target     = $urandom();
      branch_target   = $urandom();
      trap_vector     = $urandom();
      if ($urandom_range(0, 149) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
